// File: rtl/uio_arb_pkg.sv
// Shared types and widths for the uio pin-bank arbiter.
// Widths are sized for the largest supported configuration.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        GRANT
    } arb_state_e;

    localparam int UIO_W   = 8;
    localparam int MAX_REQ = 8;
    localparam int MAX_TURN = 15;
    localparam int ID_W    = $clog2(MAX_REQ);
    localparam int TURN_W  = $clog2(MAX_TURN + 1);

    function automatic int hold_width(input int max_hold);
        return (max_hold < 2) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/uio_rr_pick.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping modulo NUM_REQ.
module uio_rr_pick
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   sum;

    always_comb begin
        dbl = {req, req};
        // Rotating the doubled vector puts the pointer slot at bit 0.
        rot = NUM_REQ'(dbl >> pointer);
        any = |rot;
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = int'(pointer) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx = ID_W'(sum);
    end

endmodule

// File: rtl/uio_bank_arbiter.sv
// Round-robin owner of the shared uio pad bank, with a high-Z
// turnaround between owners and a maximum-hold forced release.
module uio_bank_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int TURNAROUND_CYCLES = 2,
    parameter int MAX_HOLD          = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*UIO_W-1:0] req_uio_out,
    input  logic [NUM_REQ*UIO_W-1:0] req_uio_oe,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     owner_valid,
    output logic [ID_W-1:0]          owner_id,
    output logic                     timeout,
    output logic [UIO_W-1:0]         uio_out,
    output logic [UIO_W-1:0]         uio_oe
);

    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LAST =
        (TURNAROUND_CYCLES == 0) ? '0 : TURN_W'(TURNAROUND_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_INIT =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(1);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     pend_q, pend_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                vld_q, vld_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                to_q, to_d;
    logic [UIO_W-1:0]    out_q, out_d;
    logic [UIO_W-1:0]    oe_q, oe_d;

    logic                pick_any;
    logic [ID_W-1:0]     pick_idx;
    logic                own_req;
    logic                pend_req;
    logic                others;
    logic [UIO_W-1:0]    own_out;
    logic [UIO_W-1:0]    own_oe;
    logic                do_grant;
    logic                do_rel;
    logic [ID_W-1:0]     grant_idx;
    int                  nxt_ptr;

    uio_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    always_comb begin
        own_req  = 1'b0;
        pend_req = 1'b0;
        own_out  = '0;
        own_oe   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id_q == ID_W'(i)) begin
                own_req = req[i];
                own_out = req_uio_out[i*UIO_W +: UIO_W];
                own_oe  = req_uio_oe[i*UIO_W +: UIO_W];
            end
            if (pend_q == ID_W'(i)) pend_req = req[i];
        end
        others  = |(req & ~gnt_q);
        nxt_ptr = int'(id_q) + 1;
        if (nxt_ptr >= NUM_REQ) nxt_ptr = 0;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pend_d    = pend_q;
        turn_d    = turn_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        vld_d     = vld_q;
        id_d      = id_q;
        to_d      = 1'b0;
        out_d     = out_q;
        oe_d      = oe_q;
        do_grant  = 1'b0;
        do_rel    = 1'b0;
        grant_idx = pend_q;

        unique case (state_q)
            IDLE: begin
                out_d = '0;
                oe_d  = '0;
                if (pick_any) begin
                    pend_d = pick_idx;
                    if (TURNAROUND_CYCLES == 0) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_idx;
                    end else begin
                        state_d = TURN;
                        turn_d  = '0;
                    end
                end
            end
            TURN: begin
                out_d = '0;
                oe_d  = '0;
                if (turn_q == TURN_LAST) begin
                    if (pend_req) do_grant = 1'b1;
                    else          state_d  = IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            GRANT: begin
                out_d = own_out;
                oe_d  = own_oe;
                if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                // A simultaneous voluntary drop wins over the forced path.
                if (!own_req) begin
                    do_rel = 1'b1;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX
                             && others) begin
                    do_rel = 1'b1;
                    to_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d = GRANT;
            vld_d   = 1'b1;
            id_d    = grant_idx;
            hold_d  = HOLD_INIT;
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt_d[i] = (grant_idx == ID_W'(i));
            end
        end

        if (do_rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
            out_d   = '0;
            oe_d    = '0;
            ptr_d   = ID_W'(nxt_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pend_q  <= '0;
            turn_q  <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            to_q    <= 1'b0;
            out_q   <= '0;
            oe_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            turn_q  <= turn_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            to_q    <= to_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner_valid = vld_q;
    assign owner_id    = id_q;
    assign timeout     = to_q;
    assign uio_out     = out_q;
    assign uio_oe      = oe_q;

endmodule

// File: tb/tb_uio_bank_arbiter.sv
// Directed bench for uio_bank_arbiter (4 requesters, turnaround 2,
// max hold 8): per-cycle vector table plus a few corner sequences.
module tb_uio_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_uio_out;
    logic [31:0] req_uio_oe;
    logic [3:0]  gnt;
    logic        owner_valid;
    logic [2:0]  owner_id;
    logic        timeout;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int checks;
    int failures;

    typedef struct {
        int         n;
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       vld;
        logic [2:0] id;
        logic [7:0] oe;
        logic [7:0] out;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    uio_bank_arbiter #(
        .NUM_REQ           (4),
        .TURNAROUND_CYCLES (2),
        .MAX_HOLD          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_uio_out (req_uio_out),
        .req_uio_oe  (req_uio_oe),
        .gnt         (gnt),
        .owner_valid (owner_valid),
        .owner_id    (owner_id),
        .timeout     (timeout),
        .uio_out     (uio_out),
        .uio_oe      (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic row(input int n, input logic r, input logic [3:0] rq,
                       input logic [3:0] g, input logic v,
                       input logic [2:0] id, input logic [7:0] oe,
                       input logic [7:0] o, input logic t);
        vec_t e;
        e.n = n; e.rst = r; e.req = rq; e.gnt = g; e.vld = v;
        e.id = id; e.oe = oe; e.out = o; e.to = t;
        tbl.push_back(e);
    endtask

    task automatic wait_gnt(input string name, input logic [3:0] exp,
                            input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (gnt === exp) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        // slice3..slice0
        req_uio_out = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_uio_oe  = {8'hF0, 8'hFF, 8'h0F, 8'h3C};

        // n  rst req      gnt      vld id  oe     out    to
        // reset hold, then round robin with forced releases
        row(3, 1, 4'b1111, 4'b0000, 0, 0, 8'h00, 8'h00, 0);
        row(3, 0, 4'b1111, 4'b0000, 0, 0, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1111, 4'b0001, 1, 0, 8'h00, 8'h00, 0);
        row(7, 0, 4'b1111, 4'b0001, 1, 0, 8'h3C, 8'h11, 0);
        row(1, 0, 4'b1111, 4'b0000, 0, 0, 8'h00, 8'h00, 1);
        row(2, 0, 4'b1111, 4'b0000, 0, 0, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1111, 4'b0010, 1, 1, 8'h00, 8'h00, 0);
        row(7, 0, 4'b1111, 4'b0010, 1, 1, 8'h0F, 8'h22, 0);
        row(1, 0, 4'b1111, 4'b0000, 0, 1, 8'h00, 8'h00, 1);
        row(2, 0, 4'b1111, 4'b0000, 0, 1, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1111, 4'b0100, 1, 2, 8'h00, 8'h00, 0);
        row(7, 0, 4'b1111, 4'b0100, 1, 2, 8'hFF, 8'hA5, 0);
        row(1, 0, 4'b1111, 4'b0000, 0, 2, 8'h00, 8'h00, 1);
        row(2, 0, 4'b1111, 4'b0000, 0, 2, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1111, 4'b1000, 1, 3, 8'h00, 8'h00, 0);
        row(7, 0, 4'b1111, 4'b1000, 1, 3, 8'hF0, 8'h44, 0);
        row(1, 0, 4'b1111, 4'b0000, 0, 3, 8'h00, 8'h00, 1);
        row(2, 0, 4'b1111, 4'b0000, 0, 3, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1111, 4'b0001, 1, 0, 8'h00, 8'h00, 0);
        row(1, 1, 4'b0000, 4'b0001, 1, 0, 8'h3C, 8'h11, 0);
        row(2, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 8'h00, 0);
        // single request on slot 2, then voluntary drop
        row(3, 0, 4'b0100, 4'b0000, 0, 0, 8'h00, 8'h00, 0);
        row(1, 0, 4'b0100, 4'b0100, 1, 2, 8'h00, 8'h00, 0);
        row(3, 0, 4'b0100, 4'b0100, 1, 2, 8'hFF, 8'hA5, 0);
        row(1, 0, 4'b0000, 4'b0100, 1, 2, 8'hFF, 8'hA5, 0);
        row(1, 0, 4'b0000, 4'b0000, 0, 2, 8'h00, 8'h00, 0);
        // owner 1 releases after 3 cycles with req[3] pending
        row(1, 0, 4'b0010, 4'b0000, 0, 2, 8'h00, 8'h00, 0);
        row(2, 0, 4'b1010, 4'b0000, 0, 2, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1010, 4'b0010, 1, 1, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1010, 4'b0010, 1, 1, 8'h0F, 8'h22, 0);
        row(1, 0, 4'b1000, 4'b0010, 1, 1, 8'h0F, 8'h22, 0);
        row(3, 0, 4'b1000, 4'b0000, 0, 1, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1000, 4'b1000, 1, 3, 8'h00, 8'h00, 0);
        row(2, 0, 4'b1000, 4'b1000, 1, 3, 8'hF0, 8'h44, 0);
        row(1, 0, 4'b0000, 4'b1000, 1, 3, 8'hF0, 8'h44, 0);
        row(1, 0, 4'b0000, 4'b0000, 0, 3, 8'h00, 8'h00, 0);
        // req[3] withdrawn during turnaround
        row(1, 0, 4'b1000, 4'b0000, 0, 3, 8'h00, 8'h00, 0);
        row(5, 0, 4'b0000, 4'b0000, 0, 3, 8'h00, 8'h00, 0);
        row(3, 0, 4'b1001, 4'b0000, 0, 3, 8'h00, 8'h00, 0);
        row(1, 0, 4'b1001, 4'b0001, 1, 0, 8'h00, 8'h00, 0);
        row(1, 1, 4'b0000, 4'b0001, 1, 0, 8'h3C, 8'h11, 0);
        row(1, 0, 4'b0000, 4'b0000, 0, 0, 8'h00, 8'h00, 0);

        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                tick();
                chk($sformatf("row%0d.%0d gnt", r, c), 32'(gnt),
                    32'(tbl[r].gnt));
                chk($sformatf("row%0d.%0d valid", r, c), 32'(owner_valid),
                    32'(tbl[r].vld));
                chk($sformatf("row%0d.%0d id", r, c), 32'(owner_id),
                    32'(tbl[r].id));
                chk($sformatf("row%0d.%0d oe", r, c), 32'(uio_oe),
                    32'(tbl[r].oe));
                chk($sformatf("row%0d.%0d out", r, c), 32'(uio_out),
                    32'(tbl[r].out));
                chk($sformatf("row%0d.%0d timeout", r, c), 32'(timeout),
                    32'(tbl[r].to));
                rst = tbl[r].rst;
                req = tbl[r].req;
            end
        end

        // sole owner keeps the grant well past MAX_HOLD
        req = 4'b0001;
        repeat (3) tick();
        chk("sole first gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("sole gnt c%0d", i), 32'(gnt), 32'h1);
            chk($sformatf("sole timeout c%0d", i), 32'(timeout), 32'h0);
        end

        // saturated hold + other request + own drop: voluntary, no pulse
        req = 4'b0010;
        tick();
        chk("simul drop gnt", 32'(gnt), 32'h0);
        chk("simul drop timeout", 32'(timeout), 32'h0);

        // walk the pointer to 3, then regrant owner 2
        wait_gnt("grant owner1", 4'b0010, 10);
        req = 4'b0000;
        tick();
        req = 4'b0100;
        wait_gnt("grant owner2 a", 4'b0100, 10);
        req = 4'b0000;
        tick();
        req = 4'b0100;
        wait_gnt("grant owner2 b", 4'b0100, 10);
        tick();
        chk("owner2 oe", 32'(uio_oe), 32'hFF);
        chk("owner2 out", 32'(uio_out), 32'hA5);

        // reset mid-grant clears pointer back to 0
        rst = 1'b1;
        req = 4'b1100;
        tick();
        chk("midrst oe", 32'(uio_oe), 32'h00);
        chk("midrst gnt", 32'(gnt), 32'h0);
        chk("midrst valid", 32'(owner_valid), 32'h0);
        chk("midrst timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        repeat (2) begin
            tick();
            chk("postrst gap gnt", 32'(gnt), 32'h0);
        end
        tick();
        chk("postrst gnt", 32'(gnt), 32'b0100);
        chk("postrst id", 32'(owner_id), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
